// File: rtl/axi_forwarding_arbiter_pkg.sv
// axi_forwarding_arbiter_pkg: shared LOG2 macro and round-robin index wrap helper
`ifndef LOG2
`define LOG2(x) ((x) <= 1 ? 0 : (x) <= 2 ? 1 : (x) <= 4 ? 2 : (x) <= 8 ? 3 : 4)
`endif
package axi_forwarding_arbiter_pkg;
  function automatic int rr_wrap(input int a, input int n);
    return a >= n ? a - n : a;
  endfunction
endpackage

// File: rtl/axi_forwarding_arbiter_rr_pick.sv
// axi_rr_pick: combinational round-robin priority encoder searching upward from ptr
module axi_rr_pick
  import axi_forwarding_arbiter_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);
  int best;
  always_comb begin
    found = |req;
    index = '0;
    best = N;
    for (int i = 0; i < N; i++)
      if (req[i] && rr_wrap(i + N - int'(ptr), N) < best) begin
        best = rr_wrap(i + N - int'(ptr), N);
        index = W'(i);
      end
  end
endmodule

// File: rtl/axi_forwarding_arbiter.sv
// axi_forwarding_arbiter: round-robin packet arbiter and AXI-stream mux for one crossbar output
module axi_forwarding_arbiter
  import axi_forwarding_arbiter_pkg::*;
#(
  parameter int NUM_INPUTS = 2,
  parameter int WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  input  logic [NUM_INPUTS-1:0]       req,
  output logic [NUM_INPUTS-1:0]       ack,
  input  logic [NUM_INPUTS*WIDTH-1:0] i_tdata,
  input  logic [NUM_INPUTS-1:0]       i_tvalid,
  input  logic [NUM_INPUTS-1:0]       i_tlast,
  output logic [NUM_INPUTS-1:0]       i_tready,
  output logic [WIDTH-1:0]            o_tdata,
  output logic                        o_tvalid,
  output logic                        o_tlast,
  input  logic                        o_tready,
  output logic                        busy,
  output logic [`LOG2(NUM_INPUTS):0]  sel
);
  localparam int SW = `LOG2(NUM_INPUTS) + 1;
  typedef enum logic {IDLE, FORWARD} state_t;
  state_t state;
  logic [SW-1:0] ptr, index;
  logic found;
  axi_rr_pick #(.N(NUM_INPUTS), .W(SW)) pick (
    .req(req),
    .ptr(ptr),
    .found(found),
    .index(index)
  );
  always_ff @(posedge clk)
    if (reset || clear) begin
      state <= IDLE;
      ack <= '0;
      sel <= '0;
      ptr <= '0;
      busy <= 1'b0;
    end else if (state == IDLE) begin
      if (found) begin
        state <= FORWARD;
        sel <= index;
        ack <= NUM_INPUTS'(1) << index;
        busy <= 1'b1;
      end
    end else if (o_tvalid && o_tready && o_tlast) begin
      state <= IDLE;
      ack <= '0;
      busy <= 1'b0;
      ptr <= SW'(rr_wrap(int'(sel) + 1, NUM_INPUTS));
    end
  always_comb begin
    o_tdata = '0;
    for (int i = 0; i < NUM_INPUTS; i++)
      o_tdata = ack[i] ? i_tdata[i*WIDTH +: WIDTH] : o_tdata;
  end
  assign o_tvalid = |(i_tvalid & ack);
  assign o_tlast = |(i_tlast & ack);
  assign i_tready = o_tready ? ack : '0;
endmodule
